// File: rtl/tdm_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tdm_demux                                                     |
// | Function : 4-channel TDM demultiplexer with frame flag and sync realign. |
// |            Optional slip detector: define TDM_DEMUX_SYNC_CHECK_EN.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tdm_demux #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [1:0]       slot,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } slot_t;

  slot_t            r_state;
  slot_t            w_state_nxt;
  slot_t            w_eff;
  logic [WIDTH-1:0] r_out0;
  logic [WIDTH-1:0] r_out1;
  logic [WIDTH-1:0] r_out2;
  logic [WIDTH-1:0] r_out3;
  logic             r_frame_valid;

  // sync pins the slot being captured to S0 regardless of the counter.
  always_comb begin
    w_eff       = sync ? S0 : r_state;
    w_state_nxt = r_state;
    if (en) begin
      case (w_eff)
        S0:      w_state_nxt = S1;
        S1:      w_state_nxt = S2;
        S2:      w_state_nxt = S3;
        default: w_state_nxt = S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S0;
      r_out0        <= '0;
      r_out1        <= '0;
      r_out2        <= '0;
      r_out3        <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_valid <= en && (w_eff == S3);
      if (en) begin
        case (w_eff)
          S0:      r_out0 <= in;
          S1:      r_out1 <= in;
          S2:      r_out2 <= in;
          default: r_out3 <= in;
        endcase
      end
    end
  end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic r_sync_err;

  // Sticky: a sync arriving anywhere but slot 0 means the upstream frame slipped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync_err <= 1'b0;
    end else if (en && sync && (r_state != S0)) begin
      r_sync_err <= 1'b1;
    end
  end

  assign sync_err = r_sync_err;
`else
  assign sync_err = 1'b0;
`endif

  assign out0        = r_out0;
  assign out1        = r_out1;
  assign out2        = r_out2;
  assign out3        = r_out3;
  assign slot        = r_state;
  assign frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tdm_demux                                                  |
// | Function : Directed self-checking bench for tdm_demux.                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_tdm_demux;

  localparam int WIDTH = 2;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  localparam logic c_exp_err = 1'b1;
`else
  localparam logic c_exp_err = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] in;
  logic             sync;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [1:0]       slot;
  logic             frame_valid;
  logic             sync_err;

  int n_checks;
  int n_fail;

  tdm_demux #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .in          (in),
    .sync        (sync),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .slot        (slot),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and sample 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic s, input logic [WIDTH-1:0] d);
    rst  = r;
    en   = e;
    sync = s;
    in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                            input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
    check({tag, ".out0"}, 32'(out0), 32'(e0));
    check({tag, ".out1"}, 32'(out1), 32'(e1));
    check({tag, ".out2"}, 32'(out2), 32'(e2));
    check({tag, ".out3"}, 32'(out3), 32'(e3));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; en = 1'b0; sync = 1'b0; in = '0;
    #2;

    // Reset dominates en and in
    step(1'b0, 1'b1, 1'b0, 2'd3);
    step(1'b0, 1'b1, 1'b0, 2'd3);
    check_outs("reset", 2'd0, 2'd0, 2'd0, 2'd0);
    check("reset.slot", 32'(slot), 32'd0);
    check("reset.fv", 32'(frame_valid), 32'd0);
    check("reset.err", 32'(sync_err), 32'd0);

    // Basic frame
    step(1'b1, 1'b1, 1'b1, 2'd0);
    check("basic.slot1", 32'(slot), 32'd1);
    check("basic.fv_early", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b1, 1'b0, 2'd2);
    check("basic.fv_pre", 32'(frame_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd3);
    check_outs("basic", 2'd0, 2'd1, 2'd2, 2'd3);
    check("basic.fv", 32'(frame_valid), 32'd1);
    check("basic.slot", 32'(slot), 32'd0);
    check("basic.err", 32'(sync_err), 32'd0);

    // Capture ch0=2, frame_valid drops
    step(1'b1, 1'b1, 1'b0, 2'd2);
    check("ch0.fv", 32'(frame_valid), 32'd0);
    check("ch0.slot", 32'(slot), 32'd1);

    // Stall: in toggles, sync ignored while en=0
    step(1'b1, 1'b0, 1'b0, 2'd3);
    step(1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd3);
    check_outs("stall", 2'd2, 2'd1, 2'd2, 2'd3);
    check("stall.slot", 32'(slot), 32'd1);
    check("stall.fv", 32'(frame_valid), 32'd0);
    check("stall.err", 32'(sync_err), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd1);
    check("resume.out1", 32'(out1), 32'd1);
    check("resume.slot", 32'(slot), 32'd2);

    // Realign at slot 2
    step(1'b1, 1'b1, 1'b1, 2'd3);
    check_outs("realign", 2'd3, 2'd1, 2'd2, 2'd3);
    check("realign.slot", 32'(slot), 32'd1);
    check("realign.fv", 32'(frame_valid), 32'd0);
    check("realign.err", 32'(sync_err), 32'(c_exp_err));

    // Finish the realigned frame, then two aligned frames; error stays sticky
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b1, 1'b0, 2'd2);
    check_outs("realfr", 2'd3, 2'd0, 2'd1, 2'd2);
    check("realfr.fv", 32'(frame_valid), 32'd1);
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        step(1'b1, 1'b1, (s == 0), 2'(3 - s));
        check("sticky.err", 32'(sync_err), 32'(c_exp_err));
      end
      check_outs("sticky", 2'd3, 2'd2, 2'd1, 2'd0);
      check("sticky.fv", 32'(frame_valid), 32'd1);
    end

    // sync while slot==3 captures into out0
    step(1'b1, 1'b1, 1'b1, 2'd2);
    step(1'b1, 1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b1, 1'b0, 2'd3);
    check("s3.slot_pre", 32'(slot), 32'd3);
    step(1'b1, 1'b1, 1'b1, 2'd1);
    check_outs("s3sync", 2'd1, 2'd1, 2'd3, 2'd0);
    check("s3sync.fv", 32'(frame_valid), 32'd0);
    check("s3sync.slot", 32'(slot), 32'd1);

    // Reset mid-frame
    step(1'b1, 1'b1, 1'b1, 2'd2);
    step(1'b1, 1'b1, 1'b0, 2'd3);
    step(1'b0, 1'b1, 1'b0, 2'd1);
    check_outs("midrst", 2'd0, 2'd0, 2'd0, 2'd0);
    check("midrst.slot", 32'(slot), 32'd0);
    check("midrst.fv", 32'(frame_valid), 32'd0);
    check("midrst.err", 32'(sync_err), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd3);
    step(1'b1, 1'b1, 1'b0, 2'd2);
    step(1'b1, 1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    check_outs("postrst", 2'd3, 2'd2, 2'd1, 2'd0);
    check("postrst.fv", 32'(frame_valid), 32'd1);

    // Chain: upstream mux emits ch0..ch3 = 0..3 with sync on its slot 0
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < 4; s++) begin
        step(1'b1, 1'b1, (s == 0), 2'(s));
        if (s != 3) check("chain.fv_low", 32'(frame_valid), 32'd0);
      end
      check("chain.fv", 32'(frame_valid), 32'd1);
      check_outs("chain", 2'd0, 2'd1, 2'd2, 2'd3);
    end
    check("chain.err", 32'(sync_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
